// File: rtl/bounce_sprite_gfx.sv
// bounce_sprite_gfx: pixel-colour source for the VGA timing block.
// A BOX_W x BOX_H sprite moves by (DX,DY) once per frame, reflects off the
// visible-area edges and advances its colour on every bounce. All state
// changes happen on the first blanking line, so a frame never tears.
// Colour and address are combinational from hc/vc so they line up with the
// timing block's colour inputs in the same cycle.
module bounce_sprite_gfx #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_W    = 32,
  parameter int BOX_H    = 32,
  parameter int DX       = 2,
  parameter int DY       = 1,
  parameter logic [7:0] BG_COLOR = 8'h03
) (
  input  logic        vgaclk,
  input  logic        rst,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  input  logic        pause,
  output logic [7:0]  color,
  output logic [15:0] addr,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y,
  output logic [15:0] bounce_cnt
);

  // 11-bit working constants so edge compares and sums never wrap.
  localparam logic [10:0] X_LIM = 11'(H_ACTIVE - BOX_W);
  localparam logic [10:0] Y_LIM = 11'(V_ACTIVE - BOX_H);
  localparam logic [10:0] DX_W  = 11'(DX);
  localparam logic [10:0] DY_W  = 11'(DY);
  localparam logic [10:0] BW_W  = 11'(BOX_W);
  localparam logic [10:0] BH_W  = 11'(BOX_H);
  localparam logic [10:0] HA_W  = 11'(H_ACTIVE);
  localparam logic [10:0] VA_W  = 11'(V_ACTIVE);
  localparam logic [9:0]  VTICK = 10'(V_ACTIVE);
  localparam logic [15:0] BW16  = 16'(BOX_W);

  logic [9:0]  box_x_q, box_x_d;
  logic [9:0]  box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  logic [7:0]  box_color_q, box_color_d;
  logic [15:0] bounce_cnt_q, bounce_cnt_d;

  logic        hit_x_s, hit_y_s, hit_s, tick_s;
  logic [10:0] x_w, y_w, hc_w, vc_w;
  logic        visible_s, inside_s;
  logic [15:0] dx_off_s, dy_off_s, offset_s;

  assign x_w    = {1'b0, box_x_q};
  assign y_w    = {1'b0, box_y_q};
  assign hc_w   = {1'b0, hc};
  assign vc_w   = {1'b0, vc};
  assign tick_s = (hc == 10'd0) && (vc == VTICK);

  // Next position, direction and bounce flags for the coming frame tick.
  always_comb begin
    box_x_d = box_x_q;
    dir_x_d = dir_x_q;
    hit_x_s = 1'b0;
    if (dir_x_q) begin
      if (x_w + DX_W >= X_LIM) begin
        box_x_d = X_LIM[9:0];
        dir_x_d = 1'b0;
        hit_x_s = 1'b1;
      end else begin
        box_x_d = 10'(x_w + DX_W);
      end
    end else begin
      if (x_w <= DX_W) begin
        box_x_d = 10'd0;
        dir_x_d = 1'b1;
        hit_x_s = 1'b1;
      end else begin
        box_x_d = 10'(x_w - DX_W);
      end
    end

    box_y_d = box_y_q;
    dir_y_d = dir_y_q;
    hit_y_s = 1'b0;
    if (dir_y_q) begin
      if (y_w + DY_W >= Y_LIM) begin
        box_y_d = Y_LIM[9:0];
        dir_y_d = 1'b0;
        hit_y_s = 1'b1;
      end else begin
        box_y_d = 10'(y_w + DY_W);
      end
    end else begin
      if (y_w <= DY_W) begin
        box_y_d = 10'd0;
        dir_y_d = 1'b1;
        hit_y_s = 1'b1;
      end else begin
        box_y_d = 10'(y_w - DY_W);
      end
    end

    // A corner hit still counts as a single bounce.
    hit_s = hit_x_s | hit_y_s;
    if (hit_s) begin
      box_color_d = box_color_q + 8'h25;
    end else begin
      box_color_d = box_color_q;
    end
    if (hit_s && (bounce_cnt_q != 16'hFFFF)) begin
      bounce_cnt_d = bounce_cnt_q + 16'd1;
    end else begin
      bounce_cnt_d = bounce_cnt_q;
    end
  end

  // Sprite state: reset wins, otherwise commit only on an unpaused frame tick.
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      box_x_q      <= 10'd0;
      box_y_q      <= 10'd0;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      box_color_q  <= 8'hE0;
      bounce_cnt_q <= 16'd0;
    end else if (tick_s && !pause) begin
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      box_color_q  <= box_color_d;
      bounce_cnt_q <= bounce_cnt_d;
    end else begin
      box_x_q      <= box_x_q;
      box_y_q      <= box_y_q;
      dir_x_q      <= dir_x_q;
      dir_y_q      <= dir_y_q;
      box_color_q  <= box_color_q;
      bounce_cnt_q <= bounce_cnt_q;
    end
  end

  // Zero-latency pixel path: box colour, background, or black in blanking.
  always_comb begin
    visible_s = (hc_w < HA_W) && (vc_w < VA_W);
    inside_s  = visible_s && (hc_w >= x_w) && (hc_w < x_w + BW_W)
                          && (vc_w >= y_w) && (vc_w < y_w + BH_W);
    dx_off_s  = {6'd0, hc} - {6'd0, box_x_q};
    dy_off_s  = {6'd0, vc} - {6'd0, box_y_q};
    offset_s  = dy_off_s * BW16 + dx_off_s;
    if (inside_s) begin
      color = box_color_q;
      addr  = offset_s;
    end else if (visible_s) begin
      color = BG_COLOR;
      addr  = 16'h0000;
    end else begin
      color = 8'h00;
      addr  = 16'h0000;
    end
  end

  assign box_x      = box_x_q;
  assign box_y      = box_y_q;
  assign bounce_cnt = bounce_cnt_q;

endmodule

// File: tb/tb_bounce_sprite_gfx.sv
// Self-checking bench for bounce_sprite_gfx (default parameters).
// Expected {box_x, box_y, bounce_cnt, color, addr} tuples are pushed to a
// scoreboard queue when a pixel is driven and popped/compared half a cycle
// later. A small reference model of the bounce rules tracks sprite state.
module tb_bounce_sprite_gfx;

  logic        vgaclk = 1'b0;
  logic        rst    = 1'b1;
  logic [9:0]  hc     = 10'd0;
  logic [9:0]  vc     = 10'd0;
  logic        pause  = 1'b0;
  logic [7:0]  color;
  logic [15:0] addr;
  logic [9:0]  box_x;
  logic [9:0]  box_y;
  logic [15:0] bounce_cnt;

  bounce_sprite_gfx dut (
    .vgaclk     (vgaclk),
    .rst        (rst),
    .hc         (hc),
    .vc         (vc),
    .pause      (pause),
    .color      (color),
    .addr       (addr),
    .box_x      (box_x),
    .box_y      (box_y),
    .bounce_cnt (bounce_cnt)
  );

  always #5 vgaclk = ~vgaclk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Reference model of sprite state.
  int         m_x, m_y, m_cnt;
  logic       m_dx, m_dy;
  logic [7:0] m_col;

  function automatic logic [63:0] pack(input int x, input int y, input int cnt,
                                       input logic [7:0] col, input int a);
    logic [9:0]  xx;
    logic [9:0]  yy;
    logic [15:0] cc;
    logic [15:0] aa;
    xx = 10'(x);
    yy = 10'(y);
    cc = 16'(cnt);
    aa = 16'(a);
    return {4'd0, xx, yy, cc, col, aa};
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 1'b1; m_dy = 1'b1; m_col = 8'hE0; m_cnt = 0;
  endtask

  task automatic model_tick();
    logic hit;
    hit = 1'b0;
    if (m_dx) begin
      if (m_x + 2 >= 608) begin m_x = 608; m_dx = 1'b0; hit = 1'b1; end
      else m_x = m_x + 2;
    end else begin
      if (m_x <= 2) begin m_x = 0; m_dx = 1'b1; hit = 1'b1; end
      else m_x = m_x - 2;
    end
    if (m_dy) begin
      if (m_y + 1 >= 448) begin m_y = 448; m_dy = 1'b0; hit = 1'b1; end
      else m_y = m_y + 1;
    end else begin
      if (m_y <= 1) begin m_y = 0; m_dy = 1'b1; hit = 1'b1; end
      else m_y = m_y - 1;
    end
    if (hit) begin
      m_col = m_col + 8'h25;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  endtask

  // Pop the oldest expectation and compare it with the live DUT outputs.
  task automatic sb_check();
    sb_t         e;
    logic [63:0] obs;
    obs = {4'd0, box_x, box_y, bounce_cnt, color, addr};
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed x=%0d y=%0d cnt=%0d col=%h addr=%0d required x=%0d y=%0d cnt=%0d col=%h addr=%0d",
               e.tag, obs[59:50], obs[49:40], obs[39:24], obs[23:16], obs[15:0],
               e.exp[59:50], e.exp[49:40], e.exp[39:24], e.exp[23:16], e.exp[15:0]);
      end
    end
  endtask

  // Drive a pixel, push the expectation, compare at the falling edge.
  task automatic step(input string tag, input int h, input int v, input logic [63:0] exp);
    sb_t e;
    hc = 10'(h);
    vc = 10'(v);
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge vgaclk);
    sb_check();
    @(posedge vgaclk);
    #1;
  endtask

  // One frame tick, then probe the sprite's top-left pixel against the model.
  task automatic do_tick(input logic p, input string tag);
    hc = 10'd0;
    vc = 10'd480;
    pause = p;
    @(posedge vgaclk);
    #1;
    pause = 1'b0;
    if (!p) model_tick();
    step(tag, m_x, m_y, pack(m_x, m_y, m_cnt, m_col, 0));
  endtask

  initial begin
    model_reset();
    @(posedge vgaclk);
    #1;
    step("reset_state", 0, 0, pack(0, 0, 0, 8'hE0, 0));
    rst = 1'b0;

    // First tick: plain step, no bounce.
    do_tick(1'b0, "tick1_model");
    step("tick1", 2, 1, pack(2, 1, 0, 8'hE0, 0));

    for (int t = 2; t <= 8512; t++) begin
      do_tick(1'b0, "tick_model");
      if (t == 50) begin
        // Box at (100,50).
        step("pix_origin",  100, 50,  pack(100, 50, 0, 8'hE0, 0));
        step("pix_last",    131, 81,  pack(100, 50, 0, 8'hE0, 1023));
        step("pix_right",   132, 50,  pack(100, 50, 0, 8'h03, 0));
        step("pix_left",     99, 50,  pack(100, 50, 0, 8'h03, 0));
        step("pix_below",   100, 82,  pack(100, 50, 0, 8'h03, 0));
        step("pix_hblank",  700, 50,  pack(100, 50, 0, 8'h00, 0));
        step("pix_vblank",  100, 500, pack(100, 50, 0, 8'h00, 0));
        step("vc_oor",        0, 600, pack(100, 50, 0, 8'h00, 0));
        for (int k = 0; k < 3; k++) do_tick(1'b1, "pause_tick");
        step("pause_hold",  100, 50,  pack(100, 50, 0, 8'hE0, 0));
      end
      if (t == 304) step("right_wall", 608, 304, pack(608, 304, 1, 8'h05, 0));
      if (t == 608) step("left_wall",    0, 288, pack(0, 288, 3, 8'h4F, 0));
      if (t == 8512) step("corner_once", 0, 448, pack(0, 448, 46, 8'h86, 0));
    end

    for (int t = 0; t < 200; t++) do_tick(1'b0, "tick_model");
    step("pre_reset", 400, 248, pack(400, 248, 46, m_col, 0));

    // Mid-frame reset at (320,200).
    hc = 10'd320;
    vc = 10'd200;
    rst = 1'b1;
    @(posedge vgaclk);
    #1;
    rst = 1'b0;
    model_reset();
    step("rst_midframe", 0, 201, pack(0, 0, 0, 8'h03, 0));
    step("rst_box_pix",  5, 20,  pack(0, 0, 0, 8'hE0, 645));

    // Reset beats a simultaneous tick.
    hc = 10'd0;
    vc = 10'd480;
    rst = 1'b1;
    @(posedge vgaclk);
    #1;
    rst = 1'b0;
    step("rst_over_tick", 0, 0, pack(0, 0, 0, 8'hE0, 0));
    do_tick(1'b0, "tick_after_rst");
    step("tick_after_rst", 2, 1, pack(2, 1, 0, 8'hE0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
